// File: rtl/median_linebuf_sequencer_if.sv
// median_linebuf_sequencer_if: pixel, window and line-buffer enable signals of the median sequencer
// master: sequencer side (takes pix_valid/out_ready, drives enables and window outputs)
// slave: pixel source, line-buffer controller and median kernel side
interface median_linebuf_sequencer_if #(
  parameter int NLINES = 10,
  parameter int AWIDTH = 11
);
  logic              pix_valid;
  logic              pix_ready;
  logic              out_ready;
  logic              clken;
  logic [NLINES-2:0] line_en;
  logic              pad;
  logic              win_valid;
  logic [AWIDTH-1:0] out_row;
  logic [AWIDTH-1:0] out_col;
  logic              border;
  modport master (
    input  pix_valid, out_ready,
    output pix_ready, clken, line_en, pad, win_valid, out_row, out_col, border
  );
  modport slave (
    output pix_valid, out_ready,
    input  pix_ready, clken, line_en, pad, win_valid, out_row, out_col, border
  );
endinterface

// File: rtl/median_linebuf_sequencer.sv
// median_linebuf_sequencer: frame sequencer for the median filter's cascaded line-buffer chain
// clk/rst_n: clock, asynchronous active-low reset
// start/width/height: frame start pulse and geometry, latched when start is accepted in IDLE
// bus: pixel handshake, stage enables (clken, line_en), pad, window valid/centre/border
// busy/frame_done/cfg_err: frame in progress, end-of-frame pulse, rejected-start pulse
module median_linebuf_sequencer #(
  parameter int NLINES = 10,
  parameter int HALF   = 5,
  parameter int AWIDTH = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AWIDTH-1:0]         width,
  input  logic [AWIDTH-1:0]         height,
  median_linebuf_sequencer_if.master bus,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      cfg_err
);
  // row_in runs HALF rows past height during flush, so it gets one extra bit
  localparam int RW = AWIDTH + 1;
  localparam logic [AWIDTH-1:0] ONE    = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] HALF_A = AWIDTH'(HALF);
  localparam logic [AWIDTH-1:0] MIN_W  = AWIDTH'(2 * HALF + 1);
  localparam logic [AWIDTH-1:0] MIN_H  = AWIDTH'(HALF + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t            state;
  logic [AWIDTH-1:0] w, h, col_in, r_next, out_row, out_col;
  logic [RW-1:0]     row_in;
  logic              advance, col_last, win, border_next, win_valid, border;
  assign advance = bus.out_ready & (((state == RUN) & bus.pix_valid) | (state == FLUSH));
  assign col_last = col_in == w - ONE;
  assign win = row_in >= RW'(HALF);
  assign r_next = AWIDTH'(row_in - RW'(HALF));
  assign border_next = (col_in < HALF_A) | (col_in > w - ONE - HALF_A) |
                       (r_next < HALF_A) | (r_next > h - ONE - HALF_A);
  // stage k (k=2..NLINES) starts once row k-2 has been pushed through stage k-1
  for (genvar i = 0; i < NLINES - 1; i++) begin : g_en
    assign bus.line_en[i] = advance & (row_in >= RW'(i + 1));
  end
  assign bus.pix_ready = (state == RUN) & bus.out_ready;
  assign bus.clken     = advance;
  assign bus.pad       = state == FLUSH;
  assign bus.win_valid = win_valid;
  assign bus.out_row   = out_row;
  assign bus.out_col   = out_col;
  assign bus.border    = border;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      w          <= '0;
      h          <= '0;
      col_in     <= '0;
      row_in     <= '0;
      win_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      border     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      // window data appears one cycle after its advance (SRAM read latency)
      win_valid  <= advance & win;
      if (advance & win) begin
        out_row <= r_next;
        out_col <= col_in;
        border  <= border_next;
      end
      if (advance) begin
        col_in <= col_last ? '0 : col_in + ONE;
        row_in <= col_last ? row_in + RW'(1) : row_in;
      end
      case (state)
        IDLE:
          if (start) begin
            if (width >= MIN_W && height >= MIN_H) begin
              state  <= RUN;
              w      <= width;
              h      <= height;
              col_in <= '0;
              row_in <= '0;
              busy   <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        RUN:
          if (advance & col_last & (row_in == {1'b0, h - ONE})) state <= FLUSH;
        FLUSH:
          if (advance & col_last & (row_in == {1'b0, h} + RW'(HALF - 1))) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_median_linebuf_sequencer.sv
// tb_median_linebuf_sequencer: directed checks of the median line-buffer sequencer
module tb_median_linebuf_sequencer;
  localparam int NL = 10;
  localparam int H  = 5;
  localparam int AW = 11;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] width = '0;
  logic [AW-1:0] height = '0;
  logic          busy, frame_done, cfg_err;
  median_linebuf_sequencer_if #(.NLINES(NL), .AWIDTH(AW)) bus();
  median_linebuf_sequencer #(.NLINES(NL), .HALF(H), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .width(width), .height(height),
    .bus(bus), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic mon_clr = 1'b1;
  int adv, run_adv, flush_adv, wins, er, ec, nb0, nb0_bad, brd_err, ord_err, orphan;
  int en_err, stall_err, first_win_prev, first_len0, first_len8;
  int done_cnt, done_adv, done_prev, cfg_cnt, busy_seen, prev_idx, prev_clk;
  logic exp_b;
  always @(negedge clk) begin
    if (mon_clr) begin
      adv = 0; run_adv = 0; flush_adv = 0; wins = 0; er = 0; ec = 0; nb0 = 0; nb0_bad = 0;
      brd_err = 0; ord_err = 0; orphan = 0; en_err = 0; stall_err = 0; first_win_prev = -1;
      first_len0 = -1; first_len8 = -1; done_cnt = 0; done_adv = -1; done_prev = 0;
      cfg_cnt = 0; busy_seen = 0; prev_idx = -1; prev_clk = 0;
    end else begin
      if (cfg_err) cfg_cnt++;
      if (busy) busy_seen++;
      if (!bus.out_ready && (bus.clken || (|bus.line_en) || bus.pix_ready)) stall_err++;
      if (bus.win_valid) begin
        if (wins == 0) first_win_prev = prev_clk ? prev_idx : -1;
        if (prev_clk == 0) orphan++;
        if (int'(bus.out_row) != er || int'(bus.out_col) != ec) ord_err++;
        exp_b = (ec < H) || (ec > int'(width) - 1 - H) || (er < H) || (er > int'(height) - 1 - H);
        if (bus.border !== exp_b) brd_err++;
        if (!bus.border) begin
          nb0++;
          if (!(er >= 5 && er <= 6 && ec >= 5 && ec <= 10)) nb0_bad++;
        end
        wins++;
        ec++;
        if (ec == int'(width)) begin ec = 0; er++; end
      end
      if (frame_done) begin done_cnt++; done_adv = adv; done_prev = prev_clk; end
      for (int i = 0; i < NL - 1; i++)
        if (bus.line_en[i] !== (bus.clken && adv >= int'(width) * (i + 1))) en_err++;
      if (bus.line_en[0] && first_len0 < 0) first_len0 = adv;
      if (bus.line_en[8] && first_len8 < 0) first_len8 = adv;
      if (bus.clken) begin
        if (bus.pix_ready) run_adv++;
        if (bus.pad) flush_adv++;
        prev_idx = adv;
        adv++;
      end
      prev_clk = bus.clken ? 1 : 0;
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask
  task automatic start_frame(input int w, input int h);
    @(posedge clk); #1;
    width = AW'(w);
    height = AW'(h);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int budget, input bit stall);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      if (stall) begin
        bus.out_ready = ($urandom_range(3) != 0);
        bus.pix_valid = ($urandom_range(4) != 0);
      end
      n++;
    end
    bus.out_ready = 1'b1;
    bus.pix_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_win_valid"}, int'(bus.win_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_clken"}, int'(bus.clken), 0);
    chk({tag, "_line_en"}, int'(bus.line_en), 0);
    chk({tag, "_pad"}, int'(bus.pad), 0);
    chk({tag, "_pix_ready"}, int'(bus.pix_ready), 0);
    chk({tag, "_out_row"}, int'(bus.out_row), 0);
    chk({tag, "_out_col"}, int'(bus.out_col), 0);
    chk({tag, "_border"}, int'(bus.border), 0);
  endtask
  initial begin
    bus.out_ready = 1'b1;
    bus.pix_valid = 1'b1;
    #12 check_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mon();
    start_frame(16, 12);
    wait_done("f1", 400, 1'b0);
    chk("f1_adv", adv, 272);
    chk("f1_run_adv", run_adv, 192);
    chk("f1_flush_adv", flush_adv, 80);
    chk("f1_wins", wins, 192);
    chk("f1_first_win_after", first_win_prev, 80);
    chk("f1_order_err", ord_err, 0);
    chk("f1_orphan_win", orphan, 0);
    chk("f1_border_err", brd_err, 0);
    chk("f1_inner_count", nb0, 12);
    chk("f1_inner_pos_err", nb0_bad, 0);
    chk("f1_line_en0_first", first_len0, 16);
    chk("f1_line_en8_first", first_len8, 144);
    chk("f1_line_en_err", en_err, 0);
    chk("f1_done_adv", done_adv, 272);
    chk("f1_done_after_adv", done_prev, 1);
    chk("f1_busy_after", int'(busy), 0);
    clear_mon();
    start_frame(16, 12);
    wait_done("f2", 3000, 1'b1);
    chk("f2_stall_err", stall_err, 0);
    chk("f2_adv", adv, 272);
    chk("f2_wins", wins, 192);
    chk("f2_order_err", ord_err, 0);
    chk("f2_border_err", brd_err, 0);
    chk("f2_line_en_err", en_err, 0);
    clear_mon();
    start_frame(8, 12);
    repeat (4) @(posedge clk);
    #1 chk("cfg_w_err_cnt", cfg_cnt, 1);
    chk("cfg_w_busy", busy_seen, 0);
    chk("cfg_w_adv", adv, 0);
    clear_mon();
    start_frame(16, 4);
    repeat (4) @(posedge clk);
    #1 chk("cfg_h_err_cnt", cfg_cnt, 1);
    chk("cfg_h_busy", busy_seen, 0);
    chk("cfg_h_adv", adv, 0);
    clear_mon();
    start_frame(11, 6);
    wait_done("min", 300, 1'b0);
    chk("min_cfg_err", cfg_cnt, 0);
    chk("min_adv", adv, 121);
    chk("min_wins", wins, 66);
    chk("min_first_win_after", first_win_prev, 55);
    chk("min_order_err", ord_err, 0);
    chk("min_border_err", brd_err, 0);
    chk("min_line_en_err", en_err, 0);
    clear_mon();
    start_frame(16, 12);
    for (int n = 0; n < 400 && adv < 100; n++) @(negedge clk);
    chk("abort_reached_100", adv, 100);
    #1 rst_n = 1'b0;
    #1 check_zero("abort");
    repeat (3) @(posedge clk);
    #1 chk("abort_no_done", done_cnt, 0);
    chk("abort_busy", int'(busy), 0);
    rst_n = 1'b1;
    clear_mon();
    start_frame(16, 12);
    wait_done("f3", 400, 1'b0);
    chk("f3_adv", adv, 272);
    chk("f3_wins", wins, 192);
    chk("f3_first_win_after", first_win_prev, 80);
    chk("f3_order_err", ord_err, 0);
    chk("f3_line_en_err", en_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/median_linebuf_sequencer.md
Name: median_linebuf_sequencer

Overview:
- Frame-level sequencer for the median filter's cascaded SRAM line-buffer chain.
- Accepts a raster pixel stream, drives the stage-1 write/read enable (clken) and the per-stage cascade enables (en2..enN), and flushes the trailing rows at frame end.
- Emits window-valid, window-centre coordinates and border flags to the median datapath.
- Sits between the pixel source and the line-buffer address controller plus median kernel.

Parameters:
- NLINES, 10, number of cascaded line buffers; the window is NLINES+1 rows.
- HALF, 5, window half-size; must equal NLINES/2.
- AWIDTH, 11, width of the width/height/coordinate fields.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start pulse; sampled in IDLE only.
- width  in  AWIDTH  pixels per row; latched at accepted start.
- height  in  AWIDTH  rows per frame; latched at accepted start.
- pix_valid  in  1  upstream pixel available.
- pix_ready  out  1  pixel accepted this cycle (comb) = (state==RUN) & out_ready.
- out_ready  in  1  downstream can take a window; low stalls everything.
- clken  out  1  line-buffer stage-1 enable (comb) = advance.
- line_en  out  NLINES-1  line_en[k-2] drives enk for k=2..NLINES (comb).
- pad  out  1  high during FLUSH; datapath substitutes replicated edge data.
- win_valid  out  1  registered; window centred at (out_row, out_col) is present.
- out_row  out  AWIDTH  window-centre row, registered.
- out_col  out  AWIDTH  window-centre column, registered.
- border  out  1  registered; centre lies within HALF of any image edge.
- busy  out  1  state is RUN or FLUSH.
- frame_done  out  1  one-cycle pulse at end of frame.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: state IDLE. All counters, win_valid, out_row, out_col, border, busy, frame_done, cfg_err are 0. Comb outputs are therefore 0.
- Reset asserted mid-frame aborts the frame immediately, with no frame_done.
- advance = (RUN & pix_valid & out_ready) | (FLUSH & out_ready). All counters move only on advance.
- FSM:
  - IDLE -> RUN on start when width >= 2*HALF+1 and height >= HALF+1; latch width and height; clear col_in and row_in.
  - In IDLE, a start that fails those checks pulses cfg_err and the state stays IDLE. start outside IDLE is ignored.
  - RUN -> FLUSH on the advance with col_in == width-1 and row_in == height-1.
  - FLUSH issues exactly HALF*width advances with pix_ready=0 and pad=1, then goes to DONE.
  - DONE pulses frame_done for 1 cycle and returns to IDLE.
- Counters:
  - col_in wraps width-1 -> 0 and increments row_in on wrap.
  - row_in continues counting in FLUSH, reaching height+HALF-1 on the last advance.
- Cascade enables: line_en[k-2] = advance & (row_in >= k-1). Line buffer k is written only once row k-2 has filled stage k-1. All enables saturate on once the frame passes row NLINES-1.
- Output timing:
  - win_valid is registered 1 cycle after an advance with row_in >= HALF, matching the 1-cycle SRAM read latency.
  - On that advance, out_row <= row_in-HALF and out_col <= col_in.
  - win_valid clears on any cycle without such an advance.
- border = (out_col < HALF) | (out_col > width-1-HALF) | (out_row < HALF) | (out_row > height-1-HALF). It is computed with the same registered timing as out_row/out_col.
- Arithmetic: comparisons are unsigned AWIDTH-bit. width-1-HALF is safe because width >= 2*HALF+1 is enforced.
- Simultaneous events: out_ready low freezes state, counters and the comb enables. win_valid drops to 0 on the next edge; out_row and out_col hold.
- Exactly width*height win_valid pulses occur per frame.

Test Plan:
- width=16, height=12, out_ready=1, pix_valid=1 always:
  - 192 clken in RUN, then 80 in FLUSH (272 total).
  - First win_valid 1 cycle after advance #80, with out_row=0 and out_col=0.
  - 192 win_valid total; frame_done 1 cycle after the last advance.
- Same frame, border check: exactly 12 win_valid with border=0, at out_row 5..6 and out_col 5..10.
- Same frame, cascade ramp:
  - line_en[0] first high at advance #16.
  - line_en[8] first high at advance #144.
  - All 9 stay high with clken from then on.
- Random out_ready and pix_valid toggling:
  - No clken or line_en while out_ready=0.
  - win_valid count is still 192 and the out_row/out_col sequence is raster-ordered with no gaps.
- start with width=8 (or height=4): cfg_err pulses 1 cycle, busy stays 0, no clken.
- rst low at advance #100:
  - All outputs 0 next cycle and no frame_done.
  - A following start runs a full clean 272-advance frame.
